// File: rtl/pwm_capture.sv
// PWM period/high-time capture with a two-register memory-mapped interface.
// state | meaning: IDLE = disabled, counters cleared; ARM = waiting for first rise; MEAS = counting between rises
module pwm_capture #(
  parameter int BITWIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  input  logic        pwm_in,
  output logic        irq
);

  localparam logic [BITWIDTH-1:0] CNT_MAX = '1;
  localparam logic [BITWIDTH-1:0] CNT_ONE = BITWIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t state, state_next;

  logic s1, s2, s3;
  logic rise;

  logic enable, irq_en, valid, ovf;
  logic [BITWIDTH-1:0] pcnt, hcnt, period, high;

  logic access, wr_ctrl, clr_valid, clr_ovf;
  logic arm_hit, publish, counting, ovf_set;
  logic [31:0] result_word, ctrl_word;
  logic unused_bits;

  assign unused_bits = ^{mem_addr[31:3], mem_addr[1:0], mem_wdata[31:4]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  assign access    = mem_valid & ~mem_ready;
  assign wr_ctrl   = access & (|mem_wstrb) & mem_addr[2];
  assign clr_valid = wr_ctrl & mem_wdata[1];
  assign clr_ovf   = wr_ctrl & mem_wdata[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = ARM;
      ARM: begin
        if (!enable)   state_next = IDLE;
        else if (rise) state_next = MEAS;
      end
      MEAS:    if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    arm_hit  = 1'b0;
    publish  = 1'b0;
    counting = 1'b0;
    case (state)
      ARM:  arm_hit = enable & rise;
      MEAS: begin
        publish  = enable & rise;
        counting = enable & ~rise;
      end
      default: ;
    endcase
  end

  // ovf flags the cycle pcnt reaches full scale and keeps asserting while pinned there
  assign ovf_set = counting & (pcnt >= (CNT_MAX - CNT_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      hcnt <= '0;
    end else if (arm_hit || publish) begin
      pcnt <= CNT_ONE;
      hcnt <= CNT_ONE;
    end else if (counting) begin
      if (pcnt != CNT_MAX)        pcnt <= pcnt + CNT_ONE;
      if (s2 && hcnt != CNT_MAX)  hcnt <= hcnt + CNT_ONE;
    end else begin
      pcnt <= '0;
      hcnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= '0;
      high   <= '0;
    end else if (publish) begin
      period <= pcnt;
      high   <= hcnt;
    end
  end

  // A capture in the same cycle as a software clear keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (publish)        valid <= 1'b1;
      else if (clr_valid) valid <= 1'b0;
      if (ovf_set)        ovf   <= 1'b1;
      else if (clr_ovf)   ovf   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable <= 1'b0;
      irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      enable <= mem_wdata[0];
      irq_en <= mem_wdata[3];
    end
  end

  assign result_word = {16'(period), 16'(high)};
  assign ctrl_word   = {28'b0, irq_en, ovf, valid, enable};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= access;
      if (access) mem_rdata <= mem_addr[2] ? ctrl_word : result_word;
    end
  end

  assign irq = valid & irq_en;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture: a pattern generator drives pwm_in and
// expected captures are derived from the generated high/period lengths.
module tb_pwm_capture;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        pwm_in;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // gen_mode: 0 = held low, 1 = held high, 2 = periodic gen_high/gen_period
  int gen_mode   = 0;
  int gen_period = 10;
  int gen_high   = 3;
  int gen_phase  = 0;

  pwm_capture #(.BITWIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .pwm_in    (pwm_in),
    .irq       (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // pwm_in moves 2 time units after the rising edge, like an unrelated source
  initial begin
    pwm_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (gen_mode == 2) begin
        if (gen_phase >= gen_period) gen_phase = 0;
        pwm_in = (gen_phase < gen_high);
        gen_phase = gen_phase + 1;
        if (gen_phase >= gen_period) gen_phase = 0;
      end else begin
        pwm_in = (gen_mode == 1);
        gen_phase = 0;
      end
    end
  end

  task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rdata);
    @(negedge clk);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL bus_ready_rise: got %b want 1", mem_ready);
    end
    rdata     = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL bus_ready_fall: got %b want 0", mem_ready);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    mem_valid = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    gen_mode = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b rdata=%h irq=%b want 0/0/0", mem_ready, mem_rdata, irq);
    end
    rst_n = 1'b1;
    bus_access(32'h0, 32'h0, 4'h0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_result: got %h want 00000000", d);
    end
    bus_access(32'h4, 32'h0, 4'h0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h want 00000000", d);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    bus_access(32'h4, 32'h1, 4'hF, d);
    gen_period = 10;
    gen_high = 3;
    gen_mode = 2;
    repeat (5) @(negedge clk);
    bus_access(32'h4, 32'h0, 4'h0, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL first_rise_no_publish: got ctrl %h want 00000001", d);
    end
    repeat (20) @(negedge clk);
    bus_access(32'h0, 32'h0, 4'h0, d);
    checks++;
    if (d !== 32'h000A_0003) begin
      errors++;
      $display("FAIL basic_result: got %h want 000a0003", d);
    end
    bus_access(32'h4, 32'h0, 4'h0, d);
    checks++;
    if (d !== 32'h3) begin
      errors++;
      $display("FAIL basic_valid: got ctrl %h want 00000003", d);
    end
  endtask

  task automatic test_held_valid();
    logic [3:0] exp_ready;
    exp_ready = 4'b0101;
    @(negedge clk);
    mem_addr = 32'h0;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_ready !== exp_ready[i]) begin
        errors++;
        $display("FAIL held_valid_ready[%0d]: got %b want %b", i, mem_ready, exp_ready[i]);
      end
      if (exp_ready[i]) begin
        checks++;
        if (mem_rdata !== 32'h000A_0003) begin
          errors++;
          $display("FAIL held_valid_rdata[%0d]: got %h want 000a0003", i, mem_rdata);
        end
      end
    end
    mem_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random_duty();
    logic [31:0] d, exp;
    int p, h;
    for (int it = 0; it < 6; it++) begin
      p = $urandom_range(40, 4);
      h = $urandom_range(p - 1, 1);
      gen_period = p;
      gen_high = h;
      gen_mode = 2;
      repeat (3 * p + 12) @(negedge clk);
      bus_access(32'h0, 32'h0, 4'h0, d);
      exp = {p[15:0], h[15:0]};
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL random_capture[%0d] p=%0d h=%0d: got %h want %h", it, p, h, d, exp);
      end
    end
  endtask

  task automatic test_irq_same_cycle();
    logic [31:0] d;
    gen_mode = 0;
    repeat (10) @(negedge clk);
    bus_access(32'h4, 32'h9, 4'hF, d);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_assert: got %b want 1", irq);
    end
    // pwm high issued now is detected as a rise on the 4th rising edge from here
    gen_mode = 1;
    repeat (3) @(negedge clk);
    mem_addr = 32'h4;
    mem_wdata = 32'h0B;
    mem_wstrb = 4'hF;
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear_irq: got %b want 1", irq);
    end
    bus_access(32'h4, 32'h0, 4'h0, d);
    checks++;
    if (d !== 32'h0B) begin
      errors++;
      $display("FAIL set_beats_clear_ctrl: got %h want 0000000b", d);
    end
    bus_access(32'h4, 32'h0B, 4'hF, d);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_deassert: got %b want 0", irq);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    bus_access(32'h4, 32'h7, 4'hF, d);
    repeat (65600) @(negedge clk);
    bus_access(32'h4, 32'h0, 4'h0, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL full_duty_ovf: got ctrl %h want 00000005", d);
    end
    gen_mode = 0;
    repeat (2) @(negedge clk);
    gen_mode = 1;
    repeat (2) @(negedge clk);
    gen_mode = 0;
    repeat (8) @(negedge clk);
    bus_access(32'h0, 32'h0, 4'h0, d);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL full_duty_result: got %h want ffffffff", d);
    end
    bus_access(32'h4, 32'h7, 4'hF, d);
    repeat (65600) @(negedge clk);
    bus_access(32'h4, 32'h0, 4'h0, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL zero_duty_no_publish: got ctrl %h want 00000005", d);
    end
    gen_mode = 1;
    repeat (2) @(negedge clk);
    gen_mode = 0;
    repeat (8) @(negedge clk);
    bus_access(32'h0, 32'h0, 4'h0, d);
    checks++;
    if (d !== 32'hFFFF_0002) begin
      errors++;
      $display("FAIL stuck_low_result: got %h want ffff0002", d);
    end
    bus_access(32'h4, 32'h5, 4'hF, d);
    bus_access(32'h4, 32'h0, 4'h0, d);
    checks++;
    if (d !== 32'h3) begin
      errors++;
      $display("FAIL ovf_clear: got ctrl %h want 00000003", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_access(32'h4, 32'h9, 4'hF, d);
    gen_period = 12;
    gen_high = 5;
    gen_mode = 2;
    repeat (20) @(negedge clk);
    checks++;
    if (irq !== 1'b1 || mem_rdata === 32'h0) begin
      errors++;
      $display("FAIL pre_reset_state: got irq=%b rdata=%h want irq=1 rdata nonzero", irq, mem_rdata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0 || mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got irq=%b ready=%b rdata=%h want 0/0/0", irq, mem_ready, mem_rdata);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    bus_access(32'h4, 32'h0, 4'h0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_ctrl: got %h want 00000000", d);
    end
    bus_access(32'h0, 32'h0, 4'h0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_ignored_rises: got %h want 00000000", d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_valid();
    test_random_duty();
    test_irq_same_cycle();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
